// File: rtl/cpu64_pkg.sv
// Shared types and helpers for the cpu64 run controller.
package cpu64_pkg;

    typedef enum logic [1:0] {
        RC_IDLE,
        RC_RSTSEQ,
        RC_RUN,
        RC_DONE
    } run_state_e;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/cpu64_run_chan.sv
// Per-core monitor: saturating retire counter and no-progress (stall) counter.
module cpu64_run_chan
    import cpu64_pkg::*;
#(
    parameter int STALL_CYCLES = 16,
    parameter int RET_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic             retire,
    input  logic             halt,
    output logic             stall_hit,
    output logic [RET_W-1:0] retire_cnt
);

    localparam int SW = $clog2(STALL_CYCLES + 1);

    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_nxt;

    always_comb begin
        stall_nxt = stall_cnt;
        if (retire || halt)
            stall_nxt = '0;
        else
            stall_nxt = SW'(sat_inc(64'(stall_cnt), SW));
    end

    // Judged on the value this cycle would produce, so the flag lands with the count.
    assign stall_hit = run && (32'(stall_nxt) >= 32'(STALL_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else if (run) begin
            stall_cnt <= stall_nxt;
            if (retire)
                retire_cnt <= RET_W'(sat_inc(64'(retire_cnt), RET_W));
        end
    end

endmodule

// File: rtl/cpu64_run_ctrl.sv
// Run controller: sequences core reset, then watches for all-halt, stall or timeout.
module cpu64_run_ctrl
    import cpu64_pkg::*;
#(
    parameter int NUM_CH       = 1,
    parameter int RST_CYCLES   = 2,
    parameter int MAX_CYCLES   = 20,
    parameter int STALL_CYCLES = 16,
    parameter int CNT_W        = 32,
    parameter int RET_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       retire_i,
    input  logic [NUM_CH-1:0]       halt_i,
    output logic                    dut_rst_n,
    output logic                    running,
    output logic                    done,
    output logic                    pass,
    output logic                    fail_timeout,
    output logic                    fail_stall,
    output logic [NUM_CH-1:0]       stall_ch,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [NUM_CH*RET_W-1:0] retire_cnt
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    run_state_e        state;
    run_state_e        state_nxt;
    logic [RC_W-1:0]   rst_cnt;
    logic [NUM_CH-1:0] stall_hit;
    logic [CNT_W-1:0]  cycle_nxt;
    logic              in_run;
    logic              clr;
    logic              all_halt;
    logic              any_stall;
    logic              timeout;

    assign in_run    = (state == RC_RUN);
    assign clr       = start && ((state == RC_IDLE) || (state == RC_DONE));
    assign all_halt  = &halt_i;
    assign any_stall = |stall_hit;
    assign cycle_nxt = CNT_W'(sat_inc(64'(cycle_cnt), CNT_W));
    assign timeout   = 64'(cycle_nxt) >= 64'(MAX_CYCLES - 1);

    assign running = (state == RC_RUN);
    assign done    = (state == RC_DONE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        cpu64_run_chan #(
            .STALL_CYCLES(STALL_CYCLES),
            .RET_W       (RET_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .run       (in_run),
            .retire    (retire_i[c]),
            .halt      (halt_i[c]),
            .stall_hit (stall_hit[c]),
            .retire_cnt(retire_cnt[c*RET_W +: RET_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RC_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RC_IDLE:   if (start) state_nxt = RC_RSTSEQ;
            RC_RSTSEQ: if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = RC_RUN;
            RC_RUN:    if (all_halt || any_stall || timeout) state_nxt = RC_DONE;
            RC_DONE:   if (start) state_nxt = RC_RSTSEQ;
            default:   state_nxt = RC_IDLE;
        endcase
    end

    // Result flags follow the exit priority: halt beats stall beats timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_rst_n    <= 1'b0;
            rst_cnt      <= '0;
            cycle_cnt    <= '0;
            pass         <= 1'b0;
            fail_timeout <= 1'b0;
            fail_stall   <= 1'b0;
            stall_ch     <= '0;
        end else begin
            dut_rst_n <= (state_nxt == RC_RUN) || (state_nxt == RC_DONE);
            if (clr) begin
                rst_cnt      <= '0;
                cycle_cnt    <= '0;
                pass         <= 1'b0;
                fail_timeout <= 1'b0;
                fail_stall   <= 1'b0;
                stall_ch     <= '0;
            end else begin
                if (state == RC_RSTSEQ)
                    rst_cnt <= rst_cnt + RC_W'(1);
                if (in_run) begin
                    cycle_cnt <= cycle_nxt;
                    if (all_halt) begin
                        pass <= 1'b1;
                    end else if (any_stall) begin
                        fail_stall <= 1'b1;
                        stall_ch   <= stall_hit;
                    end else if (timeout) begin
                        fail_timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu64_run_ctrl.sv
// Bench for cpu64_run_ctrl: directed table, corner sequences and random runs against a trace model.
module tb_cpu64_run_ctrl;

    localparam int MAXC   = 20;
    localparam int STALLC = 16;
    localparam int MAXC2  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start1 = 1'b0;
    logic [1:0]  ret1   = '0;
    logic [1:0]  halt1  = '0;
    logic        drst1, run1, done1, pass1, ft1, fs1;
    logic [1:0]  sch1;
    logic [31:0] cyc1;
    logic [31:0] rc1;

    logic        start2 = 1'b0;
    logic [0:0]  ret2   = '0;
    logic [0:0]  halt2  = '0;
    logic        drst2, run2, done2, pass2, ft2, fs2;
    logic [0:0]  sch2;
    logic [7:0]  cyc2;
    logic [3:0]  rc2;

    int checks = 0;
    int errors = 0;

    bit [1:0] tr_ret  [64];
    bit [1:0] tr_halt [64];

    typedef struct {
        bit       pass;
        bit       ft;
        bit       fs;
        bit [1:0] sch;
        int       cyc;
        int       r0;
        int       r1;
    } res_t;

    typedef struct {
        int   p0;
        int   p1;
        int   h0;
        int   h1;
        bit   poke;
        res_t exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    cpu64_run_ctrl #(
        .NUM_CH(2), .RST_CYCLES(2), .MAX_CYCLES(MAXC), .STALL_CYCLES(STALLC),
        .CNT_W(32), .RET_W(16)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .retire_i(ret1), .halt_i(halt1),
        .dut_rst_n(drst1), .running(run1), .done(done1), .pass(pass1),
        .fail_timeout(ft1), .fail_stall(fs1), .stall_ch(sch1),
        .cycle_cnt(cyc1), .retire_cnt(rc1)
    );

    cpu64_run_ctrl #(
        .NUM_CH(1), .RST_CYCLES(2), .MAX_CYCLES(MAXC2), .STALL_CYCLES(STALLC),
        .CNT_W(8), .RET_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .retire_i(ret2), .halt_i(halt2),
        .dut_rst_n(drst2), .running(run2), .done(done2), .pass(pass2),
        .fail_timeout(ft2), .fail_stall(fs2), .stall_ch(sch2),
        .cycle_cnt(cyc2), .retire_cnt(rc2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scan the per-cycle trace: stall length is cycles since the last retire or halt.
    task automatic model(output res_t e);
        int       last [2];
        int       r    [2];
        bit [1:0] sm;
        last = '{0, 0};
        r    = '{0, 0};
        e    = '{0, 0, 0, 2'b00, 0, 0, 0};
        for (int k = 1; k < 64; k++) begin
            sm = '0;
            for (int c = 0; c < 2; c++) begin
                if (tr_ret[k][c] && r[c] < 65535) r[c]++;
                if (tr_ret[k][c] || tr_halt[k][c]) last[c] = k;
                if (k - last[c] >= STALLC) sm[c] = 1'b1;
            end
            if (tr_halt[k] == 2'b11) e.pass = 1'b1;
            else if (sm != 0) begin e.fs = 1'b1; e.sch = sm; end
            else if (k >= MAXC - 1) e.ft = 1'b1;
            if (e.pass || e.fs || e.ft) begin
                e.cyc = k; e.r0 = r[0]; e.r1 = r[1];
                return;
            end
        end
    endtask

    task automatic run_trace(input bit poke, output res_t g, output int endc);
        int k;
        int w;
        logic [31:0] cyc_s;
        logic [31:0] rc_s;
        @(negedge clk); start1 = 1'b1; ret1 = '0; halt1 = '0;
        @(negedge clk); start1 = poke;
        w = 0;
        while (!run1 && w < 10) begin @(negedge clk); w++; end
        chk("run_entry", run1, 1);
        k = 1;
        while (!done1 && k <= 60) begin
            ret1   = tr_ret[k];
            halt1  = tr_halt[k];
            start1 = poke && (k >= 2) && (k <= 5);
            @(negedge clk);
            k++;
        end
        ret1 = '0; halt1 = '0; start1 = 1'b0;
        endc = k - 1;
        chk("run_done", done1, 1);
        chk("onehot", 64'(pass1) + 64'(ft1) + 64'(fs1), 1);
        g.pass = pass1; g.ft = ft1; g.fs = fs1; g.sch = sch1;
        g.cyc = int'(cyc1); g.r0 = int'(rc1[15:0]); g.r1 = int'(rc1[31:16]);
        cyc_s = cyc1; rc_s = rc1;
        for (int i = 0; i < 3; i++) begin
            ret1 = 2'($urandom); halt1 = 2'($urandom);
            @(negedge clk);
        end
        ret1 = '0; halt1 = '0;
        chk("freeze_cyc", cyc1, cyc_s);
        chk("freeze_ret", rc1, rc_s);
        chk("freeze_done", done1, 1);
        chk("freeze_drst", drst1, 1);
    endtask

    task automatic cmp_res(input string tag, input res_t g, input res_t e, input int endc);
        chk({tag, ".pass"}, g.pass, e.pass);
        chk({tag, ".ft"}, g.ft, e.ft);
        chk({tag, ".fs"}, g.fs, e.fs);
        chk({tag, ".sch"}, g.sch, e.sch);
        chk({tag, ".cyc"}, 64'(g.cyc), 64'(e.cyc));
        chk({tag, ".end"}, 64'(endc), 64'(e.cyc));
        chk({tag, ".r0"}, 64'(g.r0), 64'(e.r0));
        chk({tag, ".r1"}, 64'(g.r1), 64'(e.r1));
    endtask

    initial begin
        res_t g;
        res_t e;
        int   endc;
        int   n;
        int   mode [2];
        int   hon  [2];

        vecs[0] = '{3, 3, 10, 10, 0, '{1, 0, 0, 2'b00, 10, 3, 3}};
        vecs[1] = '{2, 2, 0, 0, 0,   '{0, 1, 0, 2'b00, 19, 9, 9}};
        vecs[2] = '{1, 0, 0, 0, 0,   '{0, 0, 1, 2'b10, 16, 16, 0}};
        vecs[3] = '{1, 0, 16, 16, 0, '{1, 0, 0, 2'b00, 16, 16, 0}};
        vecs[4] = '{0, 0, 0, 0, 0,   '{0, 0, 1, 2'b11, 16, 0, 0}};
        vecs[5] = '{0, 4, 5, 12, 0,  '{1, 0, 0, 2'b00, 12, 0, 3}};
        vecs[6] = '{0, 0, 3, 0, 0,   '{0, 0, 1, 2'b10, 16, 0, 0}};
        vecs[7] = '{2, 2, 0, 0, 1,   '{0, 1, 0, 2'b00, 19, 9, 9}};

        repeat (3) @(negedge clk);
        chk("rst.drst", drst1, 0);
        chk("rst.running", run1, 0);
        chk("rst.done", done1, 0);
        chk("rst.flags", {pass1, ft1, fs1, sch1}, 0);
        chk("rst.cyc", cyc1, 0);
        chk("rst.ret", rc1, 0);
        chk("rst2.drst", drst2, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset sequence timing and retire-count saturation on the single-core instance.
        start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk("seq1.drst", drst2, 0); chk("seq1.running", run2, 0);
        @(negedge clk);
        chk("seq2.drst", drst2, 0); chk("seq2.running", run2, 0);
        @(negedge clk);
        chk("seq3.drst", drst2, 1); chk("seq3.running", run2, 1);
        ret2 = 1'b1;
        n = 0;
        while (!done2 && n < 80) begin @(negedge clk); n++; end
        ret2 = 1'b0;
        chk("sat.done", done2, 1);
        chk("sat.ft", ft2, 1);
        chk("sat.pass_fs", {pass2, fs2, sch2}, 0);
        chk("sat.cyc", cyc2, MAXC2 - 1);
        chk("sat.ret", rc2, 15);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 64; k++) begin
                tr_ret[k][0]  = (vecs[v].p0 != 0) && (k % (vecs[v].p0 == 0 ? 1 : vecs[v].p0) == 0);
                tr_ret[k][1]  = (vecs[v].p1 != 0) && (k % (vecs[v].p1 == 0 ? 1 : vecs[v].p1) == 0);
                tr_halt[k][0] = (vecs[v].h0 != 0) && (k >= vecs[v].h0);
                tr_halt[k][1] = (vecs[v].h1 != 0) && (k >= vecs[v].h1);
            end
            run_trace(vecs[v].poke, g, endc);
            cmp_res($sformatf("vec%0d", v), g, vecs[v].exp, endc);

            if (v == 1) begin
                // Abort a run with rst and confirm everything drops back to idle.
                @(negedge clk); start1 = 1'b1;
                @(negedge clk); start1 = 1'b0;
                n = 0;
                while (!run1 && n < 10) begin @(negedge clk); n++; end
                ret1 = 2'b11;
                repeat (5) @(negedge clk);
                ret1 = '0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort.running", run1, 0);
                chk("abort.done", done1, 0);
                chk("abort.drst", drst1, 0);
                chk("abort.cyc", cyc1, 0);
                chk("abort.ret", rc1, 0);
                repeat (2) @(negedge clk);
                chk("abort.idle", {run1, drst1}, 0);
            end
        end

        for (int t = 0; t < 30; t++) begin
            for (int c = 0; c < 2; c++) begin
                mode[c] = int'($urandom_range(0, 2));
                hon[c]  = int'($urandom_range(1, 30));
            end
            for (int k = 0; k < 64; k++) begin
                for (int c = 0; c < 2; c++) begin
                    case (mode[c])
                        0:       tr_ret[k][c] = 1'b0;
                        1:       tr_ret[k][c] = ($urandom_range(0, 7) == 0);
                        default: tr_ret[k][c] = ($urandom_range(0, 1) == 0);
                    endcase
                    tr_halt[k][c] = (k >= hon[c]);
                end
            end
            model(e);
            run_trace(1'b0, g, endc);
            cmp_res($sformatf("rnd%0d", t), g, e, endc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
